// File: rtl/move_defs.sv
// rtl/move_defs.sv - shared move codes, face indices, FSM states and move-valid check
package move_defs;

  // Face-move codes as produced by the solver and UART loader
  localparam logic [3:0] MV_R  = 4'd2;
  localparam logic [3:0] MV_RI = 4'd3;
  localparam logic [3:0] MV_U  = 4'd4;
  localparam logic [3:0] MV_UI = 4'd5;
  localparam logic [3:0] MV_F  = 4'd6;
  localparam logic [3:0] MV_FI = 4'd7;
  localparam logic [3:0] MV_L  = 4'd8;
  localparam logic [3:0] MV_LI = 4'd9;
  localparam logic [3:0] MV_B  = 4'd10;
  localparam logic [3:0] MV_BI = 4'd11;
  localparam logic [3:0] MV_D  = 4'd12;
  localparam logic [3:0] MV_DI = 4'd13;

  // Face indices shared with move_to_step
  localparam logic [2:0] RIGHT = 3'd0;
  localparam logic [2:0] UP    = 3'd1;
  localparam logic [2:0] FRONT = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] BACK  = 3'd4;
  localparam logic [2:0] DOWN  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_SETTLE
  } seq_state_t;

  // Codes 0, 1, 14 and 15 carry no move
  function automatic logic move_valid(input logic [3:0] code);
    return (code >= MV_R) && (code <= MV_DI);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// rtl/move_fifo.sv - synchronous FIFO with flush and occupancy count
module move_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the count so the pointers can wrap freely
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - queues face moves and hands them one at a time to the stepper executor (option: MOVE_SEQ_COUNT_EN)
module move_sequencer
  import move_defs::*;
#(
  parameter int DEPTH         = 64,
  parameter int BUSY_TIMEOUT  = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             push_move,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic                   run,
  input  logic                   flush,
  output logic [3:0]             next_move,
  output logic                   move_start,
  input  logic                   move_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drop_pulse
`ifdef MOVE_SEQ_COUNT_EN
  ,
  output logic [15:0]            moves_completed
`endif
);

  localparam int TMAX = (BUSY_TIMEOUT > SETTLE_CYCLES) ? BUSY_TIMEOUT : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  seq_state_t    state;
  logic [TW-1:0] tmr;
  logic [3:0]    head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push_drop;
  logic          pop;

  assign push_ready = !full && !flush;
  assign accept     = push_valid && push_ready;
  assign push_drop  = accept && !move_valid(push_move);
  assign pop        = (state == S_IDLE) && run && !empty && !flush;

  move_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept && move_valid(push_move)),
    .push_data (push_move),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  // Issue/handshake FSM; tmr is shared by the busy timeout and the settle delay.
  // The timeout fires as the incremented count reaches BUSY_TIMEOUT-1, so
  // drop_pulse lands BUSY_TIMEOUT cycles after move_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      next_move  <= '0;
      move_start <= 1'b0;
      busy       <= 1'b0;
      drop_pulse <= 1'b0;
      tmr        <= '0;
`ifdef MOVE_SEQ_COUNT_EN
      moves_completed <= '0;
`endif
    end else begin
      move_start <= 1'b0;
      drop_pulse <= push_drop;
      case (state)
        S_IDLE: begin
          if (pop) begin
            next_move  <= head;
            move_start <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr   <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!move_done) begin
            state <= S_WAIT_DONE;
          end else if (tmr == TW'(BUSY_TIMEOUT - 2)) begin
            drop_pulse <= 1'b1;
            tmr        <= '0;
            state      <= S_SETTLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (move_done) begin
            tmr   <= '0;
            state <= S_SETTLE;
`ifdef MOVE_SEQ_COUNT_EN
            if (moves_completed != 16'hFFFF) moves_completed <= moves_completed + 16'd1;
`endif
          end
        end
        S_SETTLE: begin
          if (tmr == TW'(SETTLE_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - scoreboard bench for move_sequencer
module tb_move_sequencer;

  localparam int DEPTH         = 64;
  localparam int BUSY_TIMEOUT  = 16;
  localparam int SETTLE_CYCLES = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] push_move;
  logic       push_valid;
  logic       push_ready;
  logic       run;
  logic       flush;
  logic [3:0] next_move;
  logic       move_start;
  logic       move_done;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       drop_pulse;
`ifdef MOVE_SEQ_COUNT_EN
  logic [15:0] moves_completed;
`endif

  int passed = 0;
  int total  = 0;

  logic [3:0] exp_q[$];
  int cyc = 0;
  int start_cnt = 0;
  int drop_cnt = 0;
  int start_cyc = 0;
  int drop_cyc = 0;
  int last_start = -1000;
  int min_gap = 1000000;
  int peak = 0;

  logic exec_en;
  int   ex_cnt = 0;
  logic ex_active = 1'b0;

  move_sequencer #(
    .DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .push_move(push_move), .push_valid(push_valid),
    .push_ready(push_ready), .run(run), .flush(flush), .next_move(next_move),
    .move_start(move_start), .move_done(move_done), .busy(busy),
    .fifo_count(fifo_count), .drop_pulse(drop_pulse)
`ifdef MOVE_SEQ_COUNT_EN
    , .moves_completed(moves_completed)
`endif
  );

  always #5 clock = ~clock;

  // Model executor: done falls 3 cycles after start, rises 20 cycles later
  always @(negedge clock) begin
    if (reset) begin
      move_done = 1'b1;
      ex_active = 1'b0;
      ex_cnt    = 0;
    end else if (!exec_en) begin
      ex_active = 1'b0;
    end else if (move_start) begin
      ex_active = 1'b1;
      ex_cnt    = 0;
    end else if (ex_active) begin
      ex_cnt++;
      if (ex_cnt == 3) move_done = 1'b0;
      else if (ex_cnt == 23) begin
        move_done = 1'b1;
        ex_active = 1'b0;
      end
    end
  end

  // Output monitor: scoreboard pop on each issued move, event bookkeeping
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (move_start) begin
        start_cnt++;
        start_cyc = cyc;
        if (cyc - last_start < min_gap) min_gap = cyc - last_start;
        last_start = cyc;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_start: next_move=%0d, required no issue", next_move);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (next_move !== e) $display("FAIL sb_next_move: got %0d, required %0d", next_move, e);
          else passed++;
        end
      end
      if (drop_pulse) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  end

  task automatic push_code(input logic [3:0] c, input bit accept);
    push_move  = c;
    push_valid = 1'b1;
    if (accept && c >= 4'd2 && c <= 4'd13) exp_q.push_back(c);
    @(negedge clock);
    push_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(busy === 1'b0 && fifo_count === '0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= budget) $display("FAIL %s_idle_timeout: busy=%0b count=%0d, required idle within %0d cycles", name, busy, fifo_count, budget);
    else passed++;
  endtask

  task automatic wait_done_low(input string name, input int budget);
    int n = 0;
    while (move_done !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= budget) $display("FAIL %s_done_low_timeout: move_done=%0b, required 0 within %0d cycles", name, move_done, budget);
    else passed++;
  endtask

  task automatic test_reset();
    total++; if (next_move !== 4'd0) $display("FAIL rst_next_move: got %0d, required 0", next_move); else passed++;
    total++; if (move_start !== 1'b0) $display("FAIL rst_move_start: got %0b, required 0", move_start); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b, required 0", busy); else passed++;
    total++; if (fifo_count !== '0) $display("FAIL rst_fifo_count: got %0d, required 0", fifo_count); else passed++;
    total++; if (drop_pulse !== 1'b0) $display("FAIL rst_drop_pulse: got %0b, required 0", drop_pulse); else passed++;
    total++; if (push_ready !== 1'b1) $display("FAIL rst_push_ready: got %0b, required 1", push_ready); else passed++;
  endtask

  task automatic test_sequence();
    int s0 = start_cnt;
    run = 1'b1; exec_en = 1'b1;
    last_start = -1000; min_gap = 1000000;
    push_code(4'd2, 1); push_code(4'd5, 1); push_code(4'd6, 1);
    wait_idle("seq", 400);
    total++; if (start_cnt - s0 != 3) $display("FAIL seq_starts: got %0d, required 3", start_cnt - s0); else passed++;
    total++; if (min_gap < SETTLE_CYCLES + 1) $display("FAIL seq_gap: got %0d, required >= %0d", min_gap, SETTLE_CYCLES + 1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL seq_busy_end: got %0b, required 0", busy); else passed++;
  endtask

  task automatic test_invalid();
    int s0 = start_cnt;
    int d0 = drop_cnt;
    peak = 0;
    push_code(4'd0, 1); push_code(4'd15, 1); push_code(4'd8, 1);
    wait_idle("inv", 400);
    total++; if (drop_cnt - d0 != 2) $display("FAIL inv_drops: got %0d, required 2", drop_cnt - d0); else passed++;
    total++; if (start_cnt - s0 != 1) $display("FAIL inv_starts: got %0d, required 1", start_cnt - s0); else passed++;
    total++; if (peak != 1) $display("FAIL inv_peak_count: got %0d, required 1", peak); else passed++;
  endtask

  task automatic test_timeout();
    int d0 = drop_cnt;
    exec_en = 1'b0; move_done = 1'b1;
    push_code(4'd4, 1);
    wait_idle("tmo", 200);
    total++; if (drop_cnt - d0 != 1) $display("FAIL tmo_drops: got %0d, required 1", drop_cnt - d0); else passed++;
    total++; if (drop_cyc - start_cyc != BUSY_TIMEOUT) $display("FAIL tmo_latency: got %0d cycles, required %0d", drop_cyc - start_cyc, BUSY_TIMEOUT); else passed++;
    exec_en = 1'b1;
  endtask

  task automatic test_fill();
    int s0;
    run = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_code(4'(2 + (i % 12)), 1);
    total++; if (fifo_count !== 7'(DEPTH)) $display("FAIL fill_count: got %0d, required %0d", fifo_count, DEPTH); else passed++;
    total++; if (push_ready !== 1'b0) $display("FAIL fill_ready: got %0b, required 0", push_ready); else passed++;
    push_code(4'd7, 0);
    total++; if (fifo_count !== 7'(DEPTH)) $display("FAIL fill_extra_push: count %0d, required %0d", fifo_count, DEPTH); else passed++;
    s0 = start_cnt;
    run = 1'b1;
    wait_idle("fill", 5000);
    total++; if (start_cnt - s0 != DEPTH) $display("FAIL fill_starts: got %0d, required %0d", start_cnt - s0, DEPTH); else passed++;
  endtask

  task automatic test_flush();
    int s0 = start_cnt;
    run = 1'b1;
    for (int i = 0; i < 6; i++) push_code(4'(3 + i), 1);
    wait_done_low("flush", 50);
    total++; if (fifo_count !== 7'd5) $display("FAIL flush_pre_count: got %0d, required 5", fifo_count); else passed++;
    flush = 1'b1;
    #1;
    total++; if (push_ready !== 1'b0) $display("FAIL flush_ready: got %0b, required 0", push_ready); else passed++;
    @(negedge clock);
    flush = 1'b0;
    exp_q.delete();
    total++; if (fifo_count !== '0) $display("FAIL flush_count: got %0d, required 0", fifo_count); else passed++;
    wait_idle("flush", 200);
    total++; if (start_cnt - s0 != 1) $display("FAIL flush_starts: got %0d, required 1", start_cnt - s0); else passed++;
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    push_code(4'd9, 1);
    push_code(4'd10, 1);
    wait_done_low("rmid", 50);
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %0b, required 0", busy); else passed++;
    total++; if (next_move !== 4'd0) $display("FAIL rmid_next_move: got %0d, required 0", next_move); else passed++;
    total++; if (fifo_count !== '0) $display("FAIL rmid_fifo_count: got %0d, required 0", fifo_count); else passed++;
    total++; if (move_start !== 1'b0 || drop_pulse !== 1'b0) $display("FAIL rmid_pulses: start=%0b drop=%0b, required 0/0", move_start, drop_pulse); else passed++;
`ifdef MOVE_SEQ_COUNT_EN
    total++; if (moves_completed !== 16'd0) $display("FAIL rmid_moves_completed: got %0d, required 0", moves_completed); else passed++;
`endif
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++; if (push_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rmid_after: ready=%0b busy=%0b, required 1/0", push_ready, busy); else passed++;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; flush = 1'b0; push_valid = 1'b0; push_move = 4'd0;
    exec_en = 1'b1; move_done = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_sequence();
    test_invalid();
    test_timeout();
    test_fill();
    test_flush();
    test_reset_mid();
    total++; if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d moves never issued, required 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
